mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_starve_counter.sv | 26 ++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the fetch/data memory port arbiter
package mem_port_arbiter_pkg;

  // Each state names the response that is due on the current cycle
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESP_IF    = 2'd1,
    RESP_DM_RD = 2'd2,
    RESP_DM_WR = 2'd3
  } arb_state_t;

  localparam int unsigned STARVE_MAX_DEFAULT = 3;

  // Counter width needed to hold 0..max inclusive (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// rtl/mem_port_arbiter_starve_counter.sv - saturating fetch-denial counter with increment and clear
module starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX = STARVE_MAX_DEFAULT,
  localparam int unsigned W  = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // Clear wins over increment; the count sticks at MAX until cleared
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter between instruction fetch and data memory
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int unsigned SW = cnt_width(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_V = SW'(STARVE_MAX);

  arb_state_t    state;
  arb_state_t    state_next;
  logic [SW-1:0] starve_cnt;
  logic          if_resp;
  logic          dm_resp;
  logic          if_elig;
  logic          dm_elig;
  logic          grant_if;
  logic          grant_dm;

  // A requester whose response is on the bus this cycle sits out arbitration,
  // which lets the other side take the RAM back-to-back
  assign if_resp  = (state == RESP_IF);
  assign dm_resp  = (state == RESP_DM_RD) || (state == RESP_DM_WR);
  assign if_elig  = ~rst & if_req & ~if_resp;
  assign dm_elig  = ~rst & dm_req & ~dm_resp;
  assign grant_if = if_elig & (~dm_elig | (starve_cnt == STARVE_V));
  assign grant_dm = dm_elig & ~grant_if;

  starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc   (if_elig & ~grant_if),
    .clr   (grant_if),
    .count (starve_cnt)
  );

  // State register: remembers which response is due next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state follows the grant issued this cycle
  always_comb begin
    state_next = IDLE;
    if (grant_if) begin
      state_next = RESP_IF;
    end else if (grant_dm) begin
      state_next = dm_we ? RESP_DM_WR : RESP_DM_RD;
    end
  end

  // RAM strobe and payload come from the granted requester, all zero when idle
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant_if) begin
      ram_en   = 1'b1;
      ram_addr = if_addr;
    end else if (grant_dm) begin
      ram_en    = 1'b1;
      ram_we    = dm_we;
      ram_addr  = dm_addr;
      ram_wdata = dm_wdata;
    end
  end

  // Response outputs; a flush drops the fetch response that is due this cycle
  always_comb begin
    if_valid = 1'b0;
    if_rdata = '0;
    dm_valid = 1'b0;
    dm_rdata = '0;
    if (!rst) begin
      unique case (state)
        RESP_IF: begin
          if (!if_flush) begin
            if_valid = 1'b1;
            if_rdata = ram_rdata;
          end
        end
        RESP_DM_RD: begin
          dm_valid = 1'b1;
          dm_rdata = ram_rdata;
        end
        RESP_DM_WR: begin
          dm_valid = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign if_stall = ~rst & if_req & ~if_valid;
  assign dm_stall = ~rst & dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        dm_stall;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q_if[$];
  exp_t        q_dm[$];
  exp_t        e_if;
  exp_t        e_dm;
  logic [31:0] mem [logic [31:0]];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  mem_port_arbiter #(.STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: one-cycle read latency, writes land at the edge
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] = ram_wdata;
      else ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
    end
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_if(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    q_if.push_back(e);
  endtask

  task automatic push_dm(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    q_dm.push_back(e);
  endtask

  // Monitor: pop and compare whenever the DUT presents a response
  always @(negedge clk) begin
    if (if_valid) begin
      if (q_if.size() == 0) begin
        total++;
        bad++;
        $display("FAIL if_unexpected: got if_valid with %h at cycle %0d, expected no response", if_rdata, cyc);
      end else begin
        e_if = q_if.pop_front();
        chk("if_rdata", 65'(if_rdata), 65'(e_if.data));
        chk("if_cycle", 65'(cyc), 65'(e_if.cyc));
      end
    end
    if (dm_valid) begin
      if (q_dm.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dm_unexpected: got dm_valid with %h at cycle %0d, expected no response", dm_rdata, cyc);
      end else begin
        e_dm = q_dm.pop_front();
        chk("dm_rdata", 65'(dm_rdata), 65'(e_dm.data));
        chk("dm_cycle", 65'(cyc), 65'(e_dm.cyc));
      end
    end
    if (!ram_en) chk("ram_idle_zero", {ram_we, ram_addr, ram_wdata}, 65'h0);
  end

  initial begin
    mem[32'h100] = 32'hE3A01005;
    mem[32'h104] = 32'hE1A00000;
    mem[32'h108] = 32'hE2811001;
    mem[32'h200] = 32'h12345678;
    mem[32'h204] = 32'hA0000001;
    mem[32'h208] = 32'hA0000002;
    mem[32'h20C] = 32'hA0000003;
    mem[32'h210] = 32'hA0000004;
    mem[32'h40]  = 32'h0;

    rst = 1'b1; if_req = 1'b1; if_addr = 32'h100; if_flush = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_wdata = 32'h0;

    // Reset: everything quiet even with both requests up
    tick();
    tick();
    @(negedge clk);
    chk("rst_ram_en", 65'(ram_en), 65'h0);
    chk("rst_if_stall", 65'(if_stall), 65'h0);
    chk("rst_dm_stall", 65'(dm_stall), 65'h0);
    chk("rst_if_valid", 65'(if_valid), 65'h0);
    chk("rst_dm_valid", 65'(dm_valid), 65'h0);
    tick();
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    tick();

    // Lone fetch
    if_req = 1'b1; if_addr = 32'h100;
    push_if(32'hE3A01005, cyc + 1);
    @(negedge clk);
    chk("fetch_ram_en", 65'(ram_en), 65'h1);
    chk("fetch_ram_addr", 65'(ram_addr), 65'h100);
    chk("fetch_stall_c0", 65'(if_stall), 65'h1);
    tick();
    @(negedge clk);
    chk("fetch_stall_c1", 65'(if_stall), 65'h0);
    chk("fetch_no_regrant", 65'(ram_en), 65'h0);
    tick();
    if_req = 1'b0;
    tick();

    // Contention: data wins, fetch follows during the data response
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    push_dm(32'h12345678, cyc + 1);
    push_if(32'hE1A00000, cyc + 2);
    @(negedge clk);
    chk("cont_c0_addr", 65'(ram_addr), 65'h200);
    chk("cont_c0_dm_stall", 65'(dm_stall), 65'h1);
    tick();
    @(negedge clk);
    chk("cont_c1_addr", 65'(ram_addr), 65'h104);
    chk("cont_c1_en", 65'(ram_en), 65'h1);
    tick();
    dm_req = 1'b0;
    tick();
    if_req = 1'b0;
    tick();

    // Store, then load it back
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
    push_dm(32'h0, cyc + 1);
    @(negedge clk);
    chk("store_ram_we", 65'(ram_we), 65'h1);
    chk("store_ram_addr", 65'(ram_addr), 65'h40);
    chk("store_ram_wdata", 65'(ram_wdata), 65'hDEADBEEF);
    tick();
    tick();
    dm_we = 1'b0; dm_wdata = 32'h0;
    push_dm(32'hDEADBEEF, cyc + 1);
    tick();
    tick();
    dm_req = 1'b0;
    tick();

    // Starvation: three denied-then-abandoned fetches, the fourth contention goes to fetch
    for (int r = 0; r < 3; r++) begin
      if_req = 1'b1; if_addr = 32'h108;
      dm_req = 1'b1; dm_addr = 32'h204 + 32'(4 * r);
      push_dm(32'hA0000001 + 32'(r), cyc + 1);
      @(negedge clk);
      chk("starve_dm_wins", 65'(ram_addr), 65'(32'h204 + 32'(4 * r)));
      tick();
      if_req = 1'b0;
      tick();
    end
    if_req = 1'b1; if_addr = 32'h108;
    dm_req = 1'b1; dm_addr = 32'h210;
    push_if(32'hE2811001, cyc + 1);
    push_dm(32'hA0000004, cyc + 2);
    @(negedge clk);
    chk("starve_if_promoted", 65'(ram_addr), 65'h108);
    tick();
    @(negedge clk);
    chk("starve_dm_after", 65'(ram_addr), 65'h210);
    tick();
    if_req = 1'b0;
    tick();
    dm_req = 1'b0;
    tick();

    // Flush together with the grant: grant still issued, response unaffected
    if_req = 1'b1; if_addr = 32'h104; if_flush = 1'b1;
    push_if(32'hE1A00000, cyc + 1);
    @(negedge clk);
    chk("flush_grant_en", 65'(ram_en), 65'h1);
    chk("flush_grant_addr", 65'(ram_addr), 65'h104);
    tick();
    if_flush = 1'b0;
    tick();
    if_req = 1'b0;
    tick();

    // Flush in the response cycle drops the fetch for good
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    if_flush = 1'b1;
    @(negedge clk);
    chk("flush_valid", 65'(if_valid), 65'h0);
    chk("flush_stall", 65'(if_stall), 65'h1);
    tick();
    if_req = 1'b0; if_flush = 1'b0;
    repeat (3) tick();

    // Reset during the load response cycle
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_dm_valid", 65'(dm_valid), 65'h0);
    chk("rstmid_dm_rdata", 65'(dm_rdata), 65'h0);
    chk("rstmid_ram_en", 65'(ram_en), 65'h0);
    tick();
    rst = 1'b0; dm_req = 1'b0;
    repeat (3) tick();
    if_req = 1'b1; if_addr = 32'h104;
    push_if(32'hE1A00000, cyc + 1);
    tick();
    tick();
    if_req = 1'b0;
    repeat (3) tick();

    chk("if_queue_drained", 65'(q_if.size()), 65'h0);
    chk("dm_queue_drained", 65'(q_dm.size()), 65'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
